mul_div_issue_queue: RTL
========================

Name: mul_div_issue_queue

Overview:
Age-ordered issue queue for the multiply/divide functional units, directly upstream of fu_mul and fu_div.
- Accepts one dispatched mul/div micro-op per cycle.
- Tracks operand readiness by snooping two result-broadcast (CDB) ports.
- Issues at most one ready micro-op per cycle on the mul_div_issue_* bus, oldest first.
- Holds a divide while the divider reports busy (div_ready=0).

Parameters:
DEPTH, 4, number of queue entries (power of two not required, >=2)
WORD_WIDTH, 32, operand/result width
OP_WIDTH, 6, width of ALU op code (matches DATA_WIDTH_ALU_OP)
ROB_DEPTH, 32, ROB entries; tag width TW = $clog2(ROB_DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  pipeline flush; discard all entries
dispatch_en  in  1  insert micro-op this cycle
dispatch_op  in  OP_WIDTH  ALU op code
dispatch_is_div  in  1  1=DIV/DIVU/REM/REMU, 0=MUL family
dispatch_rs1_ready  in  1  rs1 value already valid
dispatch_rs1_tag  in  TW  producer ROB index of rs1
dispatch_rs1_value  in  WORD_WIDTH  rs1 value (meaningful when ready)
dispatch_rs2_ready / _tag / _value  in  1/TW/WORD_WIDTH  same for rs2
dispatch_Pdst  in  TW  destination ROB index
cdb0_valid, cdb1_valid  in  1  result broadcast valid
cdb0_Paddr, cdb1_Paddr  in  TW  broadcast ROB index
cdb0_value, cdb1_value  in  WORD_WIDTH  broadcast data
mul_ready  in  1  multiplier can accept
div_ready  in  1  divider can accept
iq_full  out  1  count==DEPTH
iq_count  out  $clog2(DEPTH+1)  valid entries
mul_div_issue_en  out  1  issue valid
mul_div_issue_queue_op  out  OP_WIDTH  issued op
mul_div_issue_queue_rs1_value  out  WORD_WIDTH  issued rs1
mul_div_issue_queue_rs2_value  out  WORD_WIDTH  issued rs2
mul_div_issue_queue_Pdst  out  TW  issued destination
mul_div_issue_is_div  out  1  issued op targets divider

Behaviour:
- Storage: compacted array, entry 0 oldest. Per entry: valid, op, is_div, rsN_ready/tag/value, Pdst. Count register.
- Reset: all entries invalid, count=0. iq_full=0, mul_div_issue_en=0, all issue data outputs 0.
- Eligibility: valid && rs1_ready && rs2_ready && (is_div ? div_ready : mul_ready).
- Select: lowest-index eligible entry. Issue outputs are combinational from registered entry state plus mul_ready/div_ready, so fu_div sees div_start in the selection cycle.
- When mul_div_issue_en=0, all issue data outputs are 0. Forced 0 while flush=1.
- Issue removal at the clock edge: entries above the issued index shift down one; count decrements.
- Dispatch:
  - Accepted iff dispatch_en && !iq_full && !flush. iq_full comes from registered count; a same-cycle issue does not free space for dispatch.
  - New entry written at index count, or count-1 if an issue occurs that cycle.
  - Rejected dispatch is silently dropped; upstream must stall on iq_full.
- Wakeup: each clock, every valid entry with rsN_ready=0 and tag==cdbK_Paddr while cdbK_valid sets rsN_ready=1 and captures cdbK_value. If both CDBs match, cdb0 wins.
- Dispatch/CDB race: a dispatching operand not ready whose tag matches a same-cycle broadcast is inserted ready with the broadcast value.
- Wakeup-to-issue latency: 1 cycle; a broadcast at cycle t makes the entry eligible at t+1. No same-cycle bypass into selection.
- Dispatch-to-issue: an entry with both operands ready is issuable the cycle after insertion at earliest.
- Divider serialization: since div_ready falls the cycle after issue, no second divide is selected until div_ready returns. Younger eligible muls bypass a blocked divide.
- Flush: at the edge, all entries invalidated, count=0. Flush overrides same-cycle dispatch, wakeup and issue removal.
- Reset mid-operation: immediate clear, asynchronous. No partial state survives.
- Count never exceeds DEPTH and never underflows. Simultaneous issue+dispatch keeps count unchanged.

Test Plan:
1. Reset, then dispatch MUL (op=MUL, rs1=7, rs2=6 both ready, Pdst=3) -> next cycle issue_en=1, rs1=7, rs2=6, Pdst=3, is_div=0; count returns 0 after.
2. Dispatch DIV with rs2_ready=0, tag=9; cdb1_valid, Paddr=9, value=2 two cycles later -> issue exactly one cycle after the broadcast with rs2_value=2.
3. Two ready DIVs (Pdst 4, 5) with div_ready pulsed as fu_div does -> Pdst 4 issues, Pdst 5 held until div_ready=1 again; a MUL dispatched behind it issues meanwhile.
4. Fill DEPTH=4 entries, all not ready -> iq_full=1; a 5th dispatch is dropped and count stays 4. Wake entry 2 -> it issues, entries 3 shift to 2, count=3.
5. Dispatch with rs1_tag=12 not ready concurrent with cdb0 Paddr=12 value=0xAA -> entry inserted ready, issues next cycle with rs1=0xAA.
6. Queue holding 3 entries, flush asserted together with dispatch_en -> count=0 next cycle, no issue during the flush cycle, and the dispatch is discarded.

Source files
------------

// File: rtl/mul_div_issue_queue_if.sv
// Bus bundle between the rename/dispatch stage, the CDB and the mul/div issue queue.
// master: dispatch side (drives dispatch, CDB, flush and FU ready; observes status/issue).
// slave:  the issue queue itself.
interface mul_div_issue_queue_if #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 6,
  parameter int unsigned ROB_DEPTH  = 32
);
  localparam int unsigned TW = $clog2(ROB_DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  dispatch_en;
  logic [OP_WIDTH-1:0]   dispatch_op;
  logic                  dispatch_is_div;
  logic                  dispatch_rs1_ready;
  logic [TW-1:0]         dispatch_rs1_tag;
  logic [WORD_WIDTH-1:0] dispatch_rs1_value;
  logic                  dispatch_rs2_ready;
  logic [TW-1:0]         dispatch_rs2_tag;
  logic [WORD_WIDTH-1:0] dispatch_rs2_value;
  logic [TW-1:0]         dispatch_Pdst;
  logic                  cdb0_valid;
  logic [TW-1:0]         cdb0_Paddr;
  logic [WORD_WIDTH-1:0] cdb0_value;
  logic                  cdb1_valid;
  logic [TW-1:0]         cdb1_Paddr;
  logic [WORD_WIDTH-1:0] cdb1_value;
  logic                  mul_ready;
  logic                  div_ready;
  logic                  iq_full;
  logic [CW-1:0]         iq_count;
  logic                  mul_div_issue_en;
  logic [OP_WIDTH-1:0]   mul_div_issue_queue_op;
  logic [WORD_WIDTH-1:0] mul_div_issue_queue_rs1_value;
  logic [WORD_WIDTH-1:0] mul_div_issue_queue_rs2_value;
  logic [TW-1:0]         mul_div_issue_queue_Pdst;
  logic                  mul_div_issue_is_div;

  modport master (
    output flush, dispatch_en, dispatch_op, dispatch_is_div,
           dispatch_rs1_ready, dispatch_rs1_tag, dispatch_rs1_value,
           dispatch_rs2_ready, dispatch_rs2_tag, dispatch_rs2_value, dispatch_Pdst,
           cdb0_valid, cdb0_Paddr, cdb0_value, cdb1_valid, cdb1_Paddr, cdb1_value,
           mul_ready, div_ready,
    input  iq_full, iq_count, mul_div_issue_en, mul_div_issue_queue_op,
           mul_div_issue_queue_rs1_value, mul_div_issue_queue_rs2_value,
           mul_div_issue_queue_Pdst, mul_div_issue_is_div
  );

  modport slave (
    input  flush, dispatch_en, dispatch_op, dispatch_is_div,
           dispatch_rs1_ready, dispatch_rs1_tag, dispatch_rs1_value,
           dispatch_rs2_ready, dispatch_rs2_tag, dispatch_rs2_value, dispatch_Pdst,
           cdb0_valid, cdb0_Paddr, cdb0_value, cdb1_valid, cdb1_Paddr, cdb1_value,
           mul_ready, div_ready,
    output iq_full, iq_count, mul_div_issue_en, mul_div_issue_queue_op,
           mul_div_issue_queue_rs1_value, mul_div_issue_queue_rs2_value,
           mul_div_issue_queue_Pdst, mul_div_issue_is_div
  );
endinterface

// File: rtl/mul_div_issue_queue.sv
// Age-ordered issue queue feeding fu_mul / fu_div.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mul_div_issue_queue_if.slave -- dispatch in, two CDB snoop ports,
//                FU ready inputs, iq_full/iq_count status, and the combinational issue bus.
// Entries are kept compacted with index 0 the oldest; the issued entry is squeezed out
// by shifting the younger ones down one slot.
module mul_div_issue_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 6,
  parameter int unsigned ROB_DEPTH  = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  mul_div_issue_queue_if.slave bus
);

  localparam int unsigned TW = $clog2(ROB_DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [OP_WIDTH-1:0]   op;
    logic                  is_div;
    logic                  rs1_ready;
    logic [TW-1:0]         rs1_tag;
    logic [WORD_WIDTH-1:0] rs1_value;
    logic                  rs2_ready;
    logic [TW-1:0]         rs2_tag;
    logic [WORD_WIDTH-1:0] rs2_value;
    logic [TW-1:0]         pdst;
  } entry_t;

  entry_t        entry_q [DEPTH];
  entry_t        entry_d [DEPTH];
  entry_t        woke    [DEPTH];
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0] elig;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  entry_t           sel_entry;
  logic             issue;
  logic             full;
  logic             accept;
  logic [CW-1:0]    wr_idx;
  entry_t           new_entry;

  // Capture a broadcast into any still-pending operand; cdb0 has priority.
  function automatic entry_t wake_operands(input entry_t e,
                                           input logic c0v, input logic [TW-1:0] c0a,
                                           input logic [WORD_WIDTH-1:0] c0d,
                                           input logic c1v, input logic [TW-1:0] c1a,
                                           input logic [WORD_WIDTH-1:0] c1d);
    entry_t r;
    r = e;
    if (r.valid && !r.rs1_ready) begin
      if (c0v && (c0a == r.rs1_tag)) begin
        r.rs1_ready = 1'b1;
        r.rs1_value = c0d;
      end else if (c1v && (c1a == r.rs1_tag)) begin
        r.rs1_ready = 1'b1;
        r.rs1_value = c1d;
      end
    end
    if (r.valid && !r.rs2_ready) begin
      if (c0v && (c0a == r.rs2_tag)) begin
        r.rs2_ready = 1'b1;
        r.rs2_value = c0d;
      end else if (c1v && (c1a == r.rs2_tag)) begin
        r.rs2_ready = 1'b1;
        r.rs2_value = c1d;
      end
    end
    return r;
  endfunction

  assign full = (count_q == CW'(DEPTH));

  // Eligibility uses registered ready bits only: no same-cycle CDB bypass into select.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = entry_q[i].valid && entry_q[i].rs1_ready && entry_q[i].rs2_ready &&
                (entry_q[i].is_div ? bus.div_ready : bus.mul_ready);
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && elig[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
        sel_entry = entry_q[i];
      end
    end
  end

  assign issue = sel_found && !bus.flush;

  always_comb begin
    bus.iq_full                       = full;
    bus.iq_count                      = count_q;
    bus.mul_div_issue_en              = issue;
    bus.mul_div_issue_queue_op        = '0;
    bus.mul_div_issue_queue_rs1_value = '0;
    bus.mul_div_issue_queue_rs2_value = '0;
    bus.mul_div_issue_queue_Pdst      = '0;
    bus.mul_div_issue_is_div          = 1'b0;
    if (issue) begin
      bus.mul_div_issue_queue_op        = sel_entry.op;
      bus.mul_div_issue_queue_rs1_value = sel_entry.rs1_value;
      bus.mul_div_issue_queue_rs2_value = sel_entry.rs2_value;
      bus.mul_div_issue_queue_Pdst      = sel_entry.pdst;
      bus.mul_div_issue_is_div          = sel_entry.is_div;
    end
  end

  always_comb begin
    // Space check uses the registered count: an issue this cycle frees no slot for dispatch.
    accept = bus.dispatch_en && !full && !bus.flush;
    wr_idx = issue ? (count_q - CW'(1)) : count_q;

    new_entry.valid     = 1'b1;
    new_entry.op        = bus.dispatch_op;
    new_entry.is_div    = bus.dispatch_is_div;
    new_entry.rs1_ready = bus.dispatch_rs1_ready;
    new_entry.rs1_tag   = bus.dispatch_rs1_tag;
    new_entry.rs1_value = bus.dispatch_rs1_value;
    new_entry.rs2_ready = bus.dispatch_rs2_ready;
    new_entry.rs2_tag   = bus.dispatch_rs2_tag;
    new_entry.rs2_value = bus.dispatch_rs2_value;
    new_entry.pdst      = bus.dispatch_Pdst;
    new_entry = wake_operands(new_entry, bus.cdb0_valid, bus.cdb0_Paddr, bus.cdb0_value,
                              bus.cdb1_valid, bus.cdb1_Paddr, bus.cdb1_value);

    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = wake_operands(entry_q[i], bus.cdb0_valid, bus.cdb0_Paddr, bus.cdb0_value,
                              bus.cdb1_valid, bus.cdb1_Paddr, bus.cdb1_value);
    end

    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = woke[i];
    end
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel_idx)) begin
          entry_d[i] = woke[i+1];
        end
      end
      entry_d[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (wr_idx == CW'(i))) begin
        entry_d[i] = new_entry;
      end
    end

    count_d = count_q;
    if (issue) begin
      count_d = count_d - CW'(1);
    end
    if (accept) begin
      count_d = count_d + CW'(1);
    end

    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_d[i] = '0;
      end
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule
